// File: rtl/memory_walker_pkg.sv
// memwalk_pkg: shared FSM state encoding and error-counter limit for memory_walker
package memwalk_pkg;
  typedef enum logic [2:0] {IDLE, RD_PRE, W_PRE, WR, RD_POST, W_POST, DONE} state_t;
  localparam logic [7:0] ERR_MAX = 8'd255;
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == ERR_MAX) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/memory_walker_if.sv
// memory_walker_if: single-port synchronous RAM bus between the walker and the RAM
interface memory_walker_if #(parameter int DATA_W = 16, parameter int ADDR_W = 10);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  modport master(output mem_addr, mem_wdata, mem_we, input mem_rdata);
  modport slave(input mem_addr, mem_wdata, mem_we, output mem_rdata);
endinterface

// File: rtl/memory_walker_button_conditioner.sv
// button_conditioner: synchronises and debounces an active-low button, emits one pulse per accepted press
module button_conditioner #(
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic button_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  logic [1:0]    sync_q, sync_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          accept;
  // cnt_q counts consecutive synchronised samples that disagree with the accepted level
  always_comb begin
    sync_d  = {sync_q[0], button_n};
    accept  = (sync_q[1] != level_q) && (cnt_q == CW'(DEBOUNCE_CYC - 1));
    cnt_d   = (sync_q[1] == level_q || accept) ? '0 : cnt_q + 1'b1;
    level_d = accept ? sync_q[1] : level_q;
    press_d = accept && !sync_q[1];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  assign press = press_q;
endmodule

// File: rtl/memory_walker.sv
// memory_walker: walks a RAM doing read-before, write pattern, read-after, compare per address
// in step (button) or auto (free-running) mode, publishing progress for board display logic.
module memory_walker
  import memwalk_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 10,
  parameter int DEPTH        = 1024,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int WRAP         = 0,
  parameter int INVERT       = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              button_n,
  input  logic              mode_auto,
  input  logic [DATA_W-1:0] seed,
  memory_walker_if.master   mem,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_write,
  output logic [DATA_W-1:0] disp_read,
  output logic              mismatch,
  output logic [7:0]        err_count,
  output logic [7:0]        pass_count,
  output logic              busy,
  output logic              done
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] seed_q, seed_d, wr_q, wr_d, rd_q, rd_d;
  logic              mis_q, mis_d;
  logic [7:0]        err_q, err_d, pass_q, pass_d;
  logic [DATA_W-1:0] sum, pat;
  logic              press, adv, last;
  button_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
    .clk(clk), .rst(rst), .button_n(button_n), .press(press)
  );
  always_comb begin
    adv     = mode_auto | press;
    sum     = DATA_W'(addr_q) + seed_q;
    pat     = (INVERT != 0) ? ~sum : sum;
    last    = addr_q == ADDR_W'(DEPTH - 1);
    state_d = state_q;
    addr_d  = addr_q;
    seed_d  = seed_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    mis_d   = mis_q;
    err_d   = err_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: if (adv) begin
        addr_d  = '0;
        seed_d  = seed;
        state_d = RD_PRE;
      end
      RD_PRE: state_d = W_PRE;
      W_PRE: if (adv) begin
        rd_d    = mem.mem_rdata;
        state_d = WR;
      end
      WR: begin
        wr_d    = pat;
        state_d = RD_POST;
      end
      RD_POST: state_d = W_POST;
      W_POST: if (adv) begin
        rd_d = mem.mem_rdata;
        if (mem.mem_rdata != pat) begin
          mis_d = 1'b1;
          err_d = sat_inc(err_q);
        end
        if (!last) begin
          addr_d  = addr_q + 1'b1;
          state_d = RD_PRE;
        end else if (WRAP != 0) begin
          addr_d  = '0;
          pass_d  = pass_q + 8'd1;
          seed_d  = seed_q + 1'b1;
          state_d = RD_PRE;
        end else begin
          state_d = DONE;
        end
      end
      DONE: if (press) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      seed_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      mis_q   <= 1'b0;
      err_q   <= '0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      seed_q  <= seed_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  // write data is gated so the bus idles at zero outside WR
  assign mem.mem_addr  = addr_q;
  assign mem.mem_we    = state_q == WR;
  assign mem.mem_wdata = (state_q == WR) ? pat : '0;
  assign disp_addr     = addr_q;
  assign disp_write    = wr_q;
  assign disp_read     = rd_q;
  assign mismatch      = mis_q;
  assign err_count     = err_q;
  assign pass_count    = pass_q;
  assign busy          = state_q != IDLE && state_q != DONE;
  assign done          = state_q == DONE;
endmodule

// File: tb/tb_memory_walker.sv
// tb_memory_walker: three walker configurations against a behavioural RAM, with a write scoreboard
module tb_memory_walker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic        btn_n[3], mode[3], we_a[3], mismatch[3], busy[3], done[3];
  logic [15:0] seed[3], wd_a[3], rd_a[3], disp_write[3], disp_read[3];
  logic [9:0]  addr_a[3], disp_addr[3];
  logic [7:0]  err[3], passc[3];
  logic [15:0] ram[3][1024];
  logic        fill_en = 1'b0;
  logic [15:0] fill_val = '0;
  int          corrupt_addr[3];
  bit          corrupt_all[3];
  logic [25:0] exp_q[3][$];
  int          total = 0, bad = 0, press_cnt = 0;
  int          we_cnt[3] = '{0, 0, 0};
  for (genvar g = 0; g < 3; g++) begin : g_dut
    memory_walker_if #(.DATA_W(16), .ADDR_W(10)) mif ();
    memory_walker #(
      .DATA_W(16), .ADDR_W(10), .DEPTH(g == 1 ? 8 : 4), .DEBOUNCE_CYC(4),
      .WRAP(g == 2 ? 1 : 0), .INVERT(g == 2 ? 1 : 0)
    ) u_dut (
      .clk(clk), .rst(rst), .button_n(btn_n[g]), .mode_auto(mode[g]), .seed(seed[g]),
      .mem(mif), .disp_addr(disp_addr[g]), .disp_write(disp_write[g]), .disp_read(disp_read[g]),
      .mismatch(mismatch[g]), .err_count(err[g]), .pass_count(passc[g]), .busy(busy[g]), .done(done[g])
    );
    assign addr_a[g]     = mif.mem_addr;
    assign wd_a[g]       = mif.mem_wdata;
    assign we_a[g]       = mif.mem_we;
    assign mif.mem_rdata = rd_a[g];
  end
  always @(posedge clk)
    for (int k = 0; k < 3; k++) begin
      if (fill_en) for (int i = 0; i < 1024; i++) ram[k][i] <= fill_val;
      else if (we_a[k]) ram[k][addr_a[k]] <= wd_a[k];
      rd_a[k] <= ram[k][addr_a[k]] ^
                 ((corrupt_all[k] || corrupt_addr[k] == int'(addr_a[k])) ? 16'h0001 : 16'h0000);
    end
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, want);
    end
  endtask
  always @(negedge clk) begin
    if (g_dut[0].u_dut.u_btn.press) press_cnt++;
    for (int k = 0; k < 3; k++)
      if (we_a[k] && !rst) begin
        we_cnt[k]++;
        if (exp_q[k].size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write inst=%0d actual=%0h:%0h required=none", k, addr_a[k], wd_a[k]);
        end else check($sformatf("write%0d", k), {addr_a[k], wd_a[k]}, exp_q[k].pop_front());
      end
  end
  function automatic logic [15:0] model_pat(input int a, input int s, input bit inv);
    logic [15:0] v;
    v = 16'(a + s);
    return inv ? ~v : v;
  endfunction
  task automatic push_walk(input int k, input int depth, input int s, input int passes, input bit inv);
    for (int p = 0; p < passes; p++)
      for (int a = 0; a < depth; a++) exp_q[k].push_back({10'(a), model_pat(a, s + p, inv)});
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) exp_q[k].delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
  endtask
  task automatic fill(input logic [15:0] v);
    @(negedge clk);
    fill_val = v;
    fill_en  = 1'b1;
    @(negedge clk);
    fill_en = 1'b0;
  endtask
  task automatic press(input int k);
    btn_n[k] = 1'b0;
    repeat (12) @(negedge clk);
    btn_n[k] = 1'b1;
    repeat (12) @(negedge clk);
  endtask
  task automatic check_zero(input int k, input string nm);
    check({nm, "_ctl"}, {busy[k], done[k], mismatch[k], err[k], passc[k], we_a[k], disp_addr[k]}, 64'd0);
    check({nm, "_dat"}, {disp_write[k], disp_read[k], wd_a[k], addr_a[k]}, 64'd0);
  endtask
  task automatic run_to_done(input int k, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done[k] && cyc < 400);
  endtask
  initial begin
    int cyc, w0, p0, s, ca, nw, a;
    for (int k = 0; k < 3; k++) begin
      btn_n[k] = 1'b1;
      mode[k] = 1'b0;
      seed[k] = '0;
      corrupt_addr[k] = -1;
      corrupt_all[k] = 1'b0;
    end
    do_reset();
    for (int k = 0; k < 3; k++) check_zero(k, $sformatf("reset%0d", k));
    fill(16'hFFFF);
    seed[0] = 16'h0010;
    push_walk(0, 4, 16'h0010, 1, 1'b0);
    press(0);
    check("step_start", {busy[0], disp_addr[0]}, {1'b1, 10'd0});
    for (int i = 0; i < 4; i++) begin
      press(0);
      check("step_read_before", disp_read[0], 16'hFFFF);
      check("step_disp_write", disp_write[0], model_pat(i, 16'h0010, 1'b0));
      press(0);
      check("step_read_after", disp_read[0], model_pat(i, 16'h0010, 1'b0));
    end
    check("step_done", {done[0], busy[0], mismatch[0], err[0]}, {1'b1, 1'b0, 1'b0, 8'd0});
    check("step_queue", exp_q[0].size(), 0);
    p0 = press_cnt;
    for (int i = 0; i < 5; i++) begin
      btn_n[0] = (i % 2) != 0;
      repeat (2) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    btn_n[0] = 1'b1;
    repeat (20) @(negedge clk);
    check("bounce_presses", press_cnt - p0, 1);
    check("bounce_to_idle", {done[0], busy[0]}, 0);
    do_reset();
    fill(16'h0000);
    push_walk(1, 8, 0, 1, 1'b0);
    w0 = we_cnt[1];
    mode[1] = 1'b1;
    run_to_done(1, cyc);
    check("auto_latency", cyc - 1, 40);
    check("auto_we_cycles", we_cnt[1] - w0, 8);
    check("auto_queue", exp_q[1].size(), 0);
    check("auto_clean", {mismatch[1], err[1]}, 0);
    mode[1] = 1'b0;
    do_reset();
    ca = $urandom_range(0, 7);
    s = $urandom_range(0, 16'h0FFF);
    corrupt_addr[1] = ca;
    seed[1] = 16'(s);
    push_walk(1, 8, s, 1, 1'b0);
    mode[1] = 1'b1;
    run_to_done(1, cyc);
    check("corrupt_done", done[1], 1);
    check("corrupt_err", {mismatch[1], err[1]}, {1'b1, 8'd1});
    corrupt_addr[1] = -1;
    mode[1] = 1'b0;
    do_reset();
    fill(16'hA5A5);
    s = $urandom_range(0, 16'h0FFF);
    seed[1] = 16'(s);
    push_walk(1, 8, s, 1, 1'b0);
    nw = $urandom_range(1, 6);
    mode[1] = 1'b1;
    cyc = 0;
    w0 = 0;
    while (w0 < nw && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (we_a[1]) w0++;
    end
    check("rst_reached_wr", w0, nw);
    a = int'(addr_a[1]);
    #2 rst = 1'b1;
    mode[1] = 1'b0;
    #1 check_zero(1, "rst_in_wr");
    @(posedge clk);
    #1 check("rst_no_write", ram[1][a], 16'hA5A5);
    do_reset();
    fill(16'h0000);
    seed[2] = 16'h0000;
    push_walk(2, 4, 0, 100, 1'b1);
    @(negedge clk);
    mode[2] = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("wrap_pass_before", passc[2], 0);
    @(negedge clk);
    check("wrap_pass_after", passc[2], 1);
    check("wrap_last_write", disp_write[2], model_pat(3, 0, 1'b1));
    repeat (20) @(negedge clk);
    check("wrap_second_pass", {passc[2], mismatch[2]}, {8'd2, 1'b0});
    mode[2] = 1'b0;
    do_reset();
    s = $urandom_range(0, 16'hFFFF);
    seed[2] = 16'(s);
    corrupt_all[2] = 1'b1;
    push_walk(2, 4, s, 100, 1'b1);
    @(negedge clk);
    mode[2] = 1'b1;
    repeat (501) @(posedge clk);
    @(negedge clk);
    check("sat_mid", {mismatch[2], err[2]}, {1'b1, 8'd100});
    repeat (1100) @(posedge clk);
    @(negedge clk);
    check("sat_full", err[2], 255);
    check("sat_pass", passc[2], 80);
    mode[2] = 1'b0;
    corrupt_all[2] = 1'b0;
    do_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
